// File: rtl/placement_engine_param.sv
// Strip-based rectangle placement pipeline: input register, evaluation against
// run-time programmable strip heights, output register with saturating strike count.
module placement_engine_param #(
    parameter int NUM_STRIPS = 16,
    parameter int DIM_W      = 5,
    parameter int COORD_W    = 8,
    parameter int REGION_W   = 128,
    parameter int DEF_H      = 8,
    parameter int CNT_W      = 4
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic                          in_valid_i,
    output logic                          in_ready_o,
    input  logic [DIM_W-1:0]              width_i,
    input  logic [DIM_W-1:0]              height_i,
    output logic                          out_valid_o,
    input  logic                          out_ready_i,
    output logic [COORD_W-1:0]            x_o,
    output logic [COORD_W-1:0]            y_o,
    output logic                          strike_flag_o,
    output logic [CNT_W-1:0]              strike_o,
    input  logic                          cfg_we_i,
    input  logic [$clog2(NUM_STRIPS)-1:0] cfg_idx_i,
    input  logic [DIM_W-1:0]              cfg_h_i,
    input  logic                          clear_i
);
    localparam int IDX_W = $clog2(NUM_STRIPS);
    localparam logic [COORD_W:0] REGION_LIM = (COORD_W+1)'(REGION_W);

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] cnt_in,
                                                 input logic inc);
        if (inc && (cnt_in != '1)) return cnt_in + CNT_W'(1);
        return cnt_in;
    endfunction

    logic                 advance, commit;
    logic                 vld_p0, vld_p1;
    logic [DIM_W-1:0]     w_p0, h_p0, w_p1, h_p1;
    logic [DIM_W-1:0]     h   [NUM_STRIPS];
    logic [COORD_W-1:0]   occ [NUM_STRIPS];
    logic [CNT_W-1:0]     cnt, cnt_next;
    logic                 found, strike;
    logic [IDX_W-1:0]     sel;
    logic [COORD_W-1:0]   occ_sel, y_sel, ybase;
    logic [COORD_W:0]     end_sel;

    assign advance    = !out_valid_o | out_ready_i;
    assign in_ready_o = advance;
    assign commit     = advance & vld_p1;

    // Evaluation of the request held in stage 1; strict '<' keeps ties on the lowest strip
    always_comb begin
        found   = 1'b0;
        sel     = '0;
        occ_sel = '0;
        y_sel   = '0;
        ybase   = '0;
        for (int k = 0; k < NUM_STRIPS; k++) begin
            if ((h[k] == h_p1) && (!found || (occ[k] < occ_sel))) begin
                found   = 1'b1;
                sel     = IDX_W'(k);
                occ_sel = occ[k];
                y_sel   = ybase;
            end
            ybase = ybase + COORD_W'(h[k]);
        end
        end_sel  = {1'b0, occ_sel} + (COORD_W+1)'(w_p1);
        strike   = (w_p1 == '0) | (h_p1 == '0) | !found | (end_sel > REGION_LIM);
        cnt_next = sat_inc(cnt, strike);
    end

    // Stage 0/1 data registers
    always_ff @(posedge clk_i) begin
        if (advance) begin
            w_p0 <= width_i;
            h_p0 <= height_i;
            w_p1 <= w_p0;
            h_p1 <= h_p0;
        end
    end

    // Stage 2 output register plus occupancy, strike counter and height state
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            vld_p0        <= 1'b0;
            vld_p1        <= 1'b0;
            out_valid_o   <= 1'b0;
            x_o           <= '0;
            y_o           <= '0;
            strike_flag_o <= 1'b0;
            strike_o      <= '0;
            cnt           <= '0;
            for (int k = 0; k < NUM_STRIPS; k++) begin
                occ[k] <= '0;
                h[k]   <= DIM_W'(DEF_H);
            end
        end else begin
            if (advance) begin
                vld_p0      <= in_valid_i;
                vld_p1      <= vld_p0;
                out_valid_o <= vld_p1;
                if (vld_p1) begin
                    x_o           <= strike ? '1 : occ_sel;
                    y_o           <= strike ? '1 : y_sel;
                    strike_flag_o <= strike;
                    strike_o      <= clear_i ? '0 : cnt_next;
                end
            end
            // A clear in the commit cycle discards that result's state update
            if (clear_i) begin
                cnt <= '0;
                for (int k = 0; k < NUM_STRIPS; k++) occ[k] <= '0;
            end else if (commit) begin
                cnt <= cnt_next;
                for (int k = 0; k < NUM_STRIPS; k++) begin
                    if (!strike && (sel == IDX_W'(k))) occ[k] <= end_sel[COORD_W-1:0];
                end
            end
            for (int k = 0; k < NUM_STRIPS; k++) begin
                if (cfg_we_i && (cfg_idx_i == IDX_W'(k))) h[k] <= cfg_h_i;
            end
        end
    end
endmodule

// File: tb/tb_placement_engine_param.sv
// Randomised and directed bench for placement_engine_param with a transaction-level
// placement model and one per-cycle output compare process.
module tb_placement_engine_param;
    localparam int NS   = 16;
    localparam int DW   = 5;
    localparam int CW   = 8;
    localparam int RW   = 128;
    localparam int DH   = 8;
    localparam int KW   = 4;
    localparam int IW   = $clog2(NS);
    localparam int CMAX = (1 << KW) - 1;
    localparam int ONES = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [DW-1:0] width = '0;
    logic [DW-1:0] height = '0;
    logic          out_valid;
    logic          out_ready;
    logic [CW-1:0] x, y;
    logic          flag;
    logic [KW-1:0] strike;
    logic          cfg_we = 1'b0;
    logic [IW-1:0] cfg_idx = '0;
    logic [DW-1:0] cfg_h = '0;
    logic          clear = 1'b0;

    placement_engine_param #(
        .NUM_STRIPS(NS), .DIM_W(DW), .COORD_W(CW), .REGION_W(RW), .DEF_H(DH), .CNT_W(KW)
    ) dut (
        .clk_i(clk), .rst_i(rst_n),
        .in_valid_i(in_valid), .in_ready_o(in_ready),
        .width_i(width), .height_i(height),
        .out_valid_o(out_valid), .out_ready_i(out_ready),
        .x_o(x), .y_o(y), .strike_flag_o(flag), .strike_o(strike),
        .cfg_we_i(cfg_we), .cfg_idx_i(cfg_idx), .cfg_h_i(cfg_h),
        .clear_i(clear)
    );

    always #5 clk = ~clk;

    typedef struct { int x; int y; int flag; int cnt; int acc; } res_t;

    res_t exp_q[$];
    int   mh[NS];
    int   mocc[NS];
    int   mcnt;
    int   n_tests = 0;
    int   n_fail  = 0;
    int   cyc     = 0;
    bit   held    = 0;
    bit   lat_chk = 0;
    bit   rand_rdy = 0;
    bit   rdy_force = 1;

    // Placement rules: least-occupied matching strip, lowest index on ties
    function automatic res_t model_place(input int w, input int hh);
        res_t r;
        int sel = -1;
        r = '{default: 0};
        for (int k = 0; k < NS; k++)
            if (mh[k] == hh && (sel < 0 || mocc[k] < mocc[sel])) sel = k;
        if (w == 0 || hh == 0 || sel < 0 || mocc[sel] + w > RW) begin
            mcnt = (mcnt < CMAX) ? mcnt + 1 : CMAX;
            r.x = ONES; r.y = ONES; r.flag = 1;
        end else begin
            r.x = mocc[sel];
            for (int j = 0; j < sel; j++) r.y += mh[j];
            r.y = r.y % (1 << CW);
            mocc[sel] += w;
        end
        r.cnt = mcnt;
        return r;
    endfunction

    function automatic void model_reset();
        for (int k = 0; k < NS; k++) begin mh[k] = DH; mocc[k] = 0; end
        mcnt = 0;
    endfunction

    function automatic void model_clear();
        for (int k = 0; k < NS; k++) mocc[k] = 0;
        mcnt = 0;
    endfunction

    function automatic bit all_at(input int v);
        for (int k = 0; k < NS; k++) if (mocc[k] != v) return 0;
        return 1;
    endfunction

    task automatic check(input string name, input int act, input int expv);
        n_tests++;
        if (act != expv) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, expv);
        end
    endtask

    task automatic send(input int w, input int hh, output res_t r);
        int t = 0;
        bit rdy = 0;
        bit ok = 0;
        r = '{default: 0};
        in_valid = 1'b1; width = DW'(w); height = DW'(hh);
        while (!ok && t < 300) begin
            @(negedge clk); rdy = in_ready;
            @(posedge clk);
            if (rdy) ok = 1; else t++;
        end
        if (ok) begin
            r = model_place(w, hh);
            r.acc = cyc;
            exp_q.push_back(r);
        end else begin
            n_tests++; n_fail++;
            $display("FAIL send_timeout: request w=%0d h=%0d not accepted", w, hh);
        end
        #1 in_valid = 1'b0;
    endtask

    task automatic drain();
        int t = 0;
        while (exp_q.size() != 0 && t < 1000) begin @(posedge clk); t++; end
        if (exp_q.size() != 0) begin
            n_tests++; n_fail++;
            $display("FAIL drain_timeout: %0d results outstanding, expected 0", exp_q.size());
            exp_q.delete();
        end
        @(posedge clk); #1;
    endtask

    task automatic cfg_write(input int idx, input int hv);
        cfg_we = 1'b1; cfg_idx = IW'(idx); cfg_h = DW'(hv);
        @(posedge clk); mh[idx] = hv;
        #1 cfg_we = 1'b0;
    endtask

    task automatic clear_idle();
        clear = 1'b1;
        @(posedge clk); model_clear();
        #1 clear = 1'b0;
    endtask

    initial begin
        out_ready = 1'b1;
        forever begin
            @(posedge clk); #2;
            out_ready = rand_rdy ? ($urandom_range(0, 9) < 7) : rdy_force;
        end
    end

    // Per-cycle compare of handshake and result against the model queue
    always @(negedge clk) begin
        cyc++;
        if (rst_n) begin
            n_tests++;
            if (in_ready !== (!out_valid || out_ready)) begin
                n_fail++;
                $display("FAIL in_ready: got %0b, expected %0b", in_ready, !out_valid || out_ready);
            end
            if (out_valid) begin
                if (exp_q.size() == 0) begin
                    n_tests++; n_fail++;
                    $display("FAIL spurious_out: out_valid=1 x=%0d y=%0d, expected no result", x, y);
                end else begin
                    res_t e;
                    e = exp_q[0];
                    n_tests++;
                    if (x !== CW'(e.x) || y !== CW'(e.y) || flag !== e.flag[0] || strike !== KW'(e.cnt)) begin
                        n_fail++;
                        $display("FAIL result: got x=%0d y=%0d flag=%0d cnt=%0d, expected x=%0d y=%0d flag=%0d cnt=%0d",
                                 x, y, flag, strike, e.x, e.y, e.flag, e.cnt);
                    end
                    if (lat_chk && !held) begin
                        n_tests++;
                        if (cyc - e.acc != 3) begin
                            n_fail++;
                            $display("FAIL latency: got %0d edges, expected 2", cyc - e.acc - 1);
                        end
                    end
                    if (out_ready) void'(exp_q.pop_front());
                end
            end
            held = out_valid && !out_ready;
        end else begin
            held = 0;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        res_t r;
        model_reset();
        repeat (2) @(posedge clk); #1;
        check("rst_out_valid", int'(out_valid), 0);
        check("rst_x", int'(x), 0);
        check("rst_y", int'(y), 0);
        check("rst_flag", int'(flag), 0);
        check("rst_strike", int'(strike), 0);
        check("rst_in_ready", int'(in_ready), 1);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Back-to-back default placements down the strip stack
        lat_chk = 1;
        for (int i = 0; i < 4; i++) begin
            send(10, 8, r);
            check("b2b_x", r.x, 0);
            check("b2b_y", r.y, i * 8);
            check("b2b_cnt", r.cnt, 0);
        end
        for (int i = 4; i < 17; i++) send(10, 8, r);
        check("wrap17_x", r.x, 10);
        check("wrap17_y", r.y, 0);
        for (int n = 0; n < 400 && !all_at(120); n++) send(10, 8, r);
        check("fill_done", int'(all_at(120)), 1);
        send(10, 8, r);
        check("full_flag", r.flag, 1);
        check("full_x", r.x, 255);
        check("full_cnt", r.cnt, 1);
        send(8, 8, r);
        check("edge_fit_x", r.x, 120);
        check("edge_fit_flag", r.flag, 0);
        send(9, 8, r);
        check("edge_over_flag", r.flag, 1);
        check("edge_over_cnt", r.cnt, 2);
        drain();

        clear_idle();
        send(5, 5, r);
        check("noh_flag", r.flag, 1);
        check("noh_cnt", r.cnt, 1);
        send(0, 8, r);
        check("w0_flag", r.flag, 1);
        send(4, 0, r);
        check("h0_flag", r.flag, 1);
        drain();
        cfg_write(3, 5);
        send(4, 5, r);
        check("cfg_x", r.x, 0);
        check("cfg_y", r.y, 24);
        drain();

        // Output stall with requests in flight
        lat_chk = 0;
        rdy_force = 0;
        @(posedge clk); #3;
        for (int i = 0; i < 3; i++) send(6, 8, r);
        fork
            send(6, 8, r);
            begin
                repeat (5) @(posedge clk);
                @(negedge clk);
                check("stall_in_ready", int'(in_ready), 0);
                check("stall_out_valid", int'(out_valid), 1);
                rdy_force = 1;
            end
        join
        drain();

        // Saturation, then a clear landing on a commit
        lat_chk = 1;
        for (int i = 0; i < 20; i++) send(1, 9, r);
        check("sat_cnt", r.cnt, 15);
        drain();
        send(1, 9, r);
        check("sat_before_clear", r.cnt, 15);
        void'(exp_q.pop_back());
        r.cnt = 0;
        exp_q.push_back(r);
        @(posedge clk); #1 clear = 1'b1;
        @(posedge clk); model_clear();
        #1 clear = 1'b0;
        send(3, 8, r);
        check("post_clear_x", r.x, 0);
        check("post_clear_y", r.y, 0);
        check("post_clear_cnt", r.cnt, 0);
        drain();

        // Randomised traffic with random back-pressure
        lat_chk = 0;
        for (int blk = 0; blk < 4; blk++) begin
            rand_rdy = 1;
            for (int i = 0; i < 60; i++) begin
                int w, hh, pick;
                w = $urandom_range(0, 24);
                pick = $urandom_range(0, 9);
                hh = (pick < 6) ? 8 : (pick < 8) ? 5 : $urandom_range(0, 31);
                send(w, hh, r);
                if ($urandom_range(0, 3) == 0) begin @(posedge clk); #1; end
            end
            rand_rdy = 0;
            drain();
            cfg_write($urandom_range(0, NS - 1), ($urandom_range(0, 1) != 0) ? 5 : 8);
            if (blk == 1) clear_idle();
        end

        // Reset mid-stream drops in-flight work
        rdy_force = 0;
        @(posedge clk); #3;
        for (int i = 0; i < 3; i++) send(6, 8, r);
        rst_n = 1'b0;
        #1;
        check("mid_rst_valid", int'(out_valid), 0);
        check("mid_rst_x", int'(x), 0);
        check("mid_rst_y", int'(y), 0);
        check("mid_rst_strike", int'(strike), 0);
        exp_q.delete();
        model_reset();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        rdy_force = 1;
        check("post_rst_in_ready", int'(in_ready), 1);
        send(7, 8, r);
        check("post_rst_x", r.x, 0);
        check("post_rst_y", r.y, 0);
        drain();
        repeat (3) @(posedge clk);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
